timer_sequencer: RTL and testbench
==================================

// Module: timer_sequencer
// PURPOSE
// Avalon-MM master that owns the Qsys interval timer's s1 slave (16-bit, 3-bit word address).
// Programs the 32-bit period, starts the timer in continuous or one-shot mode, services its irq
// (clear status, count ticks) and stops it on request. Sits between the vision control logic and
// the timer, so no other master touches the timer registers.
// PARAMETERS
// COUNT_W     16  width of tick_count
// TICK_LIMIT  0   continuous mode: auto-stop after this many ticks; 0 = unlimited
// PORTS
// clk            in   1        system clock
// reset          in   1        synchronous, active-high reset
// cfg_start      in   1        pulse: (re)program and start timer
// cfg_stop       in   1        pulse: stop timer
// cfg_period     in   32       period in clk cycles; timer loaded with cfg_period-1
// cfg_continuous in   1        1 = continuous, 0 = one-shot
// tmr_address    out  3        timer s1 address
// tmr_chipselect out  1        timer s1 chipselect
// tmr_write_n    out  1        timer s1 write strobe, active low
// tmr_writedata  out  16       timer s1 write data
// tmr_readdata   in   16       timer s1 read data, valid 1 cycle after address
// tmr_irq        in   1        timer irq, level
// busy           out  1        high in every state except IDLE
// tick           out  1        1-cycle pulse per serviced timeout
// tick_count     out  COUNT_W  ticks since last accepted start; wraps
// cfg_err        out  1        1-cycle pulse: start rejected (cfg_period == 0)
// BEHAVIOUR
// - Reset: state IDLE, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0,
//   busy=0, tick=0, tick_count=0, cfg_err=0, stop_pend=0. All outputs registered.
// - Write = exactly one cycle with chipselect=1, write_n=0. Idle bus: chipselect=0, write_n=1.
// - States: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP, STOP_CLR.
// - Start (IDLE or RUN, cfg_period!=0): latch P=cfg_period-1 and mode; tick_count<=0.
//   Sequence: WR_PL (addr 2, P[15:0]) -> WR_PH (addr 3, P[31:16])
//   -> WR_CTRL (addr 1, 0x7 cont / 0x5 one-shot) -> RUN. First write is the cycle after cfg_start.
// - Start with cfg_period==0: cfg_err pulse; state and timer unchanged.
// - cfg_start in WR_PL/WR_PH/WR_CTRL/CLR_ST/WR_STOP/STOP_CLR is ignored.
// - RUN, tmr_irq=1 -> CLR_ST: write addr 0, data 0. Same cycle: tick=1, tick_count+1 (wrap).
//   Exit: one-shot -> IDLE. Continuous with TICK_LIMIT!=0 and new count==TICK_LIMIT -> WR_STOP.
//   Otherwise -> RUN. irq is low in the cycle after CLR_ST.
// - cfg_stop in RUN -> WR_STOP (addr 1, data 0x8) -> STOP_CLR (addr 0, data 0) -> IDLE.
// - cfg_stop in WR_PL/WR_PH/WR_CTRL/CLR_ST sets stop_pend. On reaching RUN, stop_pend -> WR_STOP
//   next cycle (tick cycle still counts); stop_pend is cleared in WR_STOP.
// - cfg_stop in IDLE: no bus activity.
// - RUN priority: cfg_stop/stop_pend > tmr_irq > cfg_start > snapshot request.
// - A start in RUN reprograms directly. A period write force-reloads and stops the timer;
//   the control write restarts it.
// - Reset mid-sequence aborts at once; the timer keeps its last programmed state.
// CONFIGURATION
// TIMER_SNAPSHOT_EN defined adds these ports and states:
//   snap_req (in, 1), snap_valid (out, 1-cycle pulse), snap_value (out, 32, reset 0).
//   snap_req in RUN -> SN_WR (addr 4 write, data 0) -> SN_RL (addr 4, read)
//   -> SN_RH (addr 5, read; capture readdata as low half) -> SN_DONE (capture high half,
//   snap_valid=1) -> RUN. snap_req outside RUN is dropped.
//   irq arriving during a snapshot is serviced on return to RUN; irq is level, so none is lost.
// Not defined: no snapshot ports, states or logic.
// TESTING
// 1 reset; cfg_start, period=100000, cont=1 -> writes a2=0x869F, a3=0x0001, a1=0x0007
//   on cycles 1-3; busy=1 from cycle 1.
// 2 model timer, period=10, cont=1 -> irq every 10 clk; 5 tick pulses, tick_count=5,
//   each irq cleared by an addr 0 write.
// 3 one-shot, period=20 -> one tick, returns to IDLE, busy=0, no further writes.
// 4 TICK_LIMIT=3, cont -> after 3rd tick: a1=0x8 then a0=0, IDLE; tick_count=3.
// 5 cfg_period=0 -> cfg_err pulse, no bus write. Stop during WR_PH -> full start completes,
//   then WR_STOP/STOP_CLR.
// 6 [TIMER_SNAPSHOT_EN] timer counter at 0x00012345 on snap write
//   -> snap_value=0x00012345, snap_valid one pulse, return to RUN.

Source files
------------

// File: rtl/timer_sequencer.sv
// timer_sequencer: Avalon-MM master that programs, services and stops the interval timer s1 slave.
// Define TIMER_SNAPSHOT_EN to add the counter-snapshot request/response ports and states.
module timer_sequencer #(
  parameter int COUNT_W    = 16,
  parameter int TICK_LIMIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [31:0]        cfg_period,
  input  logic               cfg_continuous,
  output logic [2:0]         tmr_address,
  output logic               tmr_chipselect,
  output logic               tmr_write_n,
  output logic [15:0]        tmr_writedata,
  input  logic [15:0]        tmr_readdata,
  input  logic               tmr_irq,
  output logic               busy,
  output logic               tick,
  output logic [COUNT_W-1:0] tick_count,
  output logic               cfg_err
`ifdef TIMER_SNAPSHOT_EN
  ,
  input  logic               snap_req,
  output logic               snap_valid,
  output logic [31:0]        snap_value
`endif
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP, STOP_CLR
`ifdef TIMER_SNAPSHOT_EN
    , SN_WR, SN_RL, SN_RH, SN_DONE
`endif
  } state_t;

  localparam logic [COUNT_W-1:0] LIMIT = COUNT_W'(TICK_LIMIT);

  state_t             state_q;
  logic [31:0]        period_q;
  logic               cont_q;
  logic               stop_pend_q;
  logic [2:0]         addr_q;
  logic               cs_q;
  logic               wn_q;
  logic [15:0]        wd_q;
  logic               busy_q;
  logic               tick_q;
  logic               err_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic [31:0]        period_d;

  // Timer counts from the loaded value down through zero, hence the -1.
  assign period_d = cfg_period - 32'd1;
  assign cnt_d    = cnt_q + COUNT_W'(1);

`ifdef TIMER_SNAPSHOT_EN
  logic [15:0] snap_lo_q;
  logic        snap_valid_q;
  logic [31:0] snap_value_q;

  assign snap_valid = snap_valid_q;
  assign snap_value = snap_value_q;
`else
  logic unused_rd;
  assign unused_rd = ^tmr_readdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      addr_q      <= 3'd0;
      wd_q        <= 16'h0000;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef TIMER_SNAPSHOT_EN
      snap_valid_q <= 1'b0;
      snap_value_q <= 32'h0;
`endif
    end else begin
      cs_q   <= 1'b0;
      wn_q   <= 1'b1;
      addr_q <= 3'd0;
      wd_q   <= 16'h0000;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b1;
`ifdef TIMER_SNAPSHOT_EN
      snap_valid_q <= 1'b0;
`endif
      // A stop arriving mid-sequence is remembered and honoured once RUN is reached.
      if (cfg_stop && !(state_q inside {IDLE, RUN, WR_STOP, STOP_CLR}))
        stop_pend_q <= 1'b1;

      case (state_q)
        IDLE, RUN: begin
          busy_q <= (state_q == RUN);
          if (state_q == RUN && (cfg_stop || stop_pend_q)) begin
            state_q <= WR_STOP;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= 3'd1;
            wd_q    <= 16'h0008;
          end else if (state_q == RUN && tmr_irq) begin
            state_q <= CLR_ST;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            tick_q  <= 1'b1;
            cnt_q   <= cnt_d;
          end else if (cfg_start) begin
            if (cfg_period == 32'd0) begin
              err_q <= 1'b1;
            end else begin
              period_q <= period_d;
              cont_q   <= cfg_continuous;
              cnt_q    <= '0;
              state_q  <= WR_PL;
              busy_q   <= 1'b1;
              cs_q     <= 1'b1;
              wn_q     <= 1'b0;
              addr_q   <= 3'd2;
              wd_q     <= period_d[15:0];
            end
          end
`ifdef TIMER_SNAPSHOT_EN
          else if (state_q == RUN && snap_req) begin
            state_q <= SN_WR;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= 3'd4;
          end
`endif
        end
        WR_PL: begin
          state_q <= WR_PH;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= 3'd3;
          wd_q    <= period_q[31:16];
        end
        WR_PH: begin
          state_q <= WR_CTRL;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= 3'd1;
          wd_q    <= cont_q ? 16'h0007 : 16'h0005;
        end
        WR_CTRL: state_q <= RUN;
        CLR_ST: begin
          if (!cont_q) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end else if (TICK_LIMIT != 0 && cnt_q == LIMIT) begin
            state_q <= WR_STOP;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= 3'd1;
            wd_q    <= 16'h0008;
          end else begin
            state_q <= RUN;
          end
        end
        WR_STOP: begin
          state_q     <= STOP_CLR;
          stop_pend_q <= 1'b0;
          cs_q        <= 1'b1;
          wn_q        <= 1'b0;
        end
        STOP_CLR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
`ifdef TIMER_SNAPSHOT_EN
        SN_WR: begin
          state_q <= SN_RL;
          cs_q    <= 1'b1;
          addr_q  <= 3'd4;
        end
        // Readdata lags the address by one cycle, so each half is captured a state later.
        SN_RL: begin
          state_q <= SN_RH;
          cs_q    <= 1'b1;
          addr_q  <= 3'd5;
        end
        SN_RH: begin
          state_q   <= SN_DONE;
          snap_lo_q <= tmr_readdata;
        end
        SN_DONE: begin
          state_q      <= RUN;
          snap_value_q <= {tmr_readdata, snap_lo_q};
          snap_valid_q <= 1'b1;
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_writedata  = wd_q;
  assign busy           = busy_q;
  assign tick           = tick_q;
  assign tick_count     = cnt_q;
  assign cfg_err        = err_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: two instances (unlimited and TICK_LIMIT=3), each against a model timer.
// Expected bus writes and snapshots are queued as stimulus is driven and popped as the DUT produces them.
module tb_timer_sequencer;
  localparam int LIM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start [2];
  logic        stop  [2];
  logic [31:0] period;
  logic        cont;
  logic [2:0]  addr  [2];
  logic        cs    [2];
  logic        wn    [2];
  logic [15:0] wd    [2];
  logic [15:0] rd    [2];
  logic        irq   [2];
  logic        busy  [2];
  logic        tick  [2];
  logic [15:0] tcnt  [2];
  logic        err   [2];
  logic        hold  [2];
`ifdef TIMER_SNAPSHOT_EN
  logic        snap_req   [2];
  logic        snap_valid [2];
  logic [31:0] snap_value [2];
  logic [31:0] sq0[$];
  int          snap_seen;
`endif

  logic [18:0] q0[$];
  logic [18:0] q1[$];
  int n_checks = 0;
  int n_errors = 0;
  int tick_seen [2];

  timer_sequencer #(.COUNT_W(16), .TICK_LIMIT(0)) dut (
    .clk(clk), .reset(reset), .cfg_start(start[0]), .cfg_stop(stop[0]),
    .cfg_period(period), .cfg_continuous(cont),
    .tmr_address(addr[0]), .tmr_chipselect(cs[0]), .tmr_write_n(wn[0]),
    .tmr_writedata(wd[0]), .tmr_readdata(rd[0]), .tmr_irq(irq[0]),
    .busy(busy[0]), .tick(tick[0]), .tick_count(tcnt[0]), .cfg_err(err[0])
`ifdef TIMER_SNAPSHOT_EN
    , .snap_req(snap_req[0]), .snap_valid(snap_valid[0]), .snap_value(snap_value[0])
`endif
  );

  timer_sequencer #(.COUNT_W(16), .TICK_LIMIT(LIM)) dut_lim (
    .clk(clk), .reset(reset), .cfg_start(start[1]), .cfg_stop(stop[1]),
    .cfg_period(period), .cfg_continuous(cont),
    .tmr_address(addr[1]), .tmr_chipselect(cs[1]), .tmr_write_n(wn[1]),
    .tmr_writedata(wd[1]), .tmr_readdata(rd[1]), .tmr_irq(irq[1]),
    .busy(busy[1]), .tick(tick[1]), .tick_count(tcnt[1]), .cfg_err(err[1])
`ifdef TIMER_SNAPSHOT_EN
    , .snap_req(snap_req[1]), .snap_valid(snap_valid[1]), .snap_value(snap_value[1])
`endif
  );

  // Model of the interval timer s1 slave, one per DUT
  logic [31:0] m_per [2];
  logic [31:0] m_cnt [2];
  logic [31:0] m_snap [2];
  logic        m_run [2];
  logic        m_cont [2];
  logic        m_ito [2];
  logic        m_to [2];
  int          m_nto [2];

  always_comb for (int i = 0; i < 2; i++) irq[i] = m_to[i] & m_ito[i];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_run[i] <= 1'b0; m_cont[i] <= 1'b0; m_ito[i] <= 1'b0; m_to[i] <= 1'b0;
        m_per[i] <= 32'h0; m_cnt[i] <= 32'h0; m_snap[i] <= 32'h0; rd[i] <= 16'h0;
        m_nto[i] <= 0;
      end else begin
        rd[i] <= 16'h0;
        if (cs[i] && wn[i])
          rd[i] <= (addr[i] == 3'd4) ? m_snap[i][15:0] : (addr[i] == 3'd5) ? m_snap[i][31:16] : 16'h0;
        if (cs[i] && !wn[i]) begin
          case (addr[i])
            3'd0: m_to[i] <= 1'b0;
            3'd1: begin
              m_ito[i]  <= wd[i][0];
              m_cont[i] <= wd[i][1];
              if (wd[i][3]) m_run[i] <= 1'b0;
              else if (wd[i][2]) m_run[i] <= 1'b1;
            end
            3'd2: begin
              m_per[i][15:0] <= wd[i];
              m_cnt[i] <= {m_per[i][31:16], wd[i]};
              m_run[i] <= 1'b0;
              m_nto[i] <= 0;
            end
            3'd3: begin
              m_per[i][31:16] <= wd[i];
              m_cnt[i] <= {wd[i], m_per[i][15:0]};
              m_run[i] <= 1'b0;
            end
            3'd4: m_snap[i] <= m_cnt[i];
            default: ;
          endcase
        end else if (hold[i]) begin
          m_cnt[i] <= 32'h0001_2345;
        end else if (m_run[i]) begin
          if (m_cnt[i] == 32'h0) begin
            m_to[i]  <= 1'b1;
            m_cnt[i] <= m_per[i];
            if (!m_cont[i]) m_run[i] <= 1'b0;
            m_nto[i] <= m_nto[i] + 1;
            if (i == 0) q0.push_back(19'h0);
            else begin
              q1.push_back(19'h0);
              if (m_cont[i] && m_nto[i] + 1 == LIM) begin
                q1.push_back({3'd1, 16'h0008});
                q1.push_back({3'd0, 16'h0000});
              end
            end
          end else begin
            m_cnt[i] <= m_cnt[i] - 32'd1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mon();
    logic [18:0] got;
    for (int i = 0; i < 2; i++) begin
      if (tick[i] === 1'b1) tick_seen[i]++;
      if (cs[i] === 1'b1 && wn[i] === 1'b0) begin
        got = {addr[i], wd[i]};
        if (i == 0) begin
          chk("bus0_write_expected", 32'(q0.size() != 0), 32'd1);
          if (q0.size() != 0) chk("bus0_write", 32'(got), 32'(q0.pop_front()));
        end else begin
          chk("bus1_write_expected", 32'(q1.size() != 0), 32'd1);
          if (q1.size() != 0) chk("bus1_write", 32'(got), 32'(q1.pop_front()));
        end
      end
    end
`ifdef TIMER_SNAPSHOT_EN
    if (snap_valid[0] === 1'b1) begin
      snap_seen++;
      chk("snap_expected", 32'(sq0.size() != 0), 32'd1);
      if (sq0.size() != 0) chk("snap_value", snap_value[0], sq0.pop_front());
    end
`endif
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
  endtask

  task automatic push(input int i, input logic [2:0] a, input logic [15:0] d);
    if (i == 0) q0.push_back({a, d});
    else q1.push_back({a, d});
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    cyc();
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget, input string tag);
    int k = 0;
    while (busy[i] !== 1'b0 && k < budget) begin cyc(); k++; end
    chk(tag, 32'(busy[i]), 32'd0);
  endtask

  task automatic wait_ticks(input int i, input int n, input int budget, input string tag);
    int k = 0;
    while (tick_seen[i] < n && k < budget) begin cyc(); k++; end
    chk(tag, tick_seen[i], n);
  endtask

  initial begin
    reset = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0; stop[0] = 1'b0; stop[1] = 1'b0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    period = 32'h0; cont = 1'b0;
    tick_seen[0] = 0; tick_seen[1] = 0;
`ifdef TIMER_SNAPSHOT_EN
    snap_req[0] = 1'b0; snap_req[1] = 1'b0; snap_seen = 0;
`endif
    repeat (3) cyc();
    reset = 1'b0;
    chk("rst_cs", 32'(cs[0]), 32'd0);
    chk("rst_write_n", 32'(wn[0]), 32'd1);
    chk("rst_addr", 32'(addr[0]), 32'd0);
    chk("rst_wdata", 32'(wd[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_tick", 32'(tick[0]), 32'd0);
    chk("rst_count", 32'(tcnt[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    chk("rst_busy_lim", 32'(busy[1]), 32'd0);

    // Programming sequence, period 100000 continuous
    period = 32'd100000; cont = 1'b1;
    push(0, 3'd2, 16'h869F); push(0, 3'd3, 16'h0001); push(0, 3'd1, 16'h0007);
    pulse_start(0);
    chk("t1_busy_c1", 32'(busy[0]), 32'd1);
    chk("t1_addr_c1", 32'(addr[0]), 32'd2);
    cyc();
    chk("t1_addr_c2", 32'(addr[0]), 32'd3);
    cyc();
    chk("t1_addr_c3", 32'(addr[0]), 32'd1);
    cyc();
    chk("t1_bus_idle_run", 32'(cs[0]), 32'd0);
    push(0, 3'd1, 16'h0008); push(0, 3'd0, 16'h0000);
    stop[0] = 1'b1; cyc(); stop[0] = 1'b0;
    wait_idle(0, 20, "t1_stop_idle");

    // Continuous period 10: five serviced ticks, stop arrives during the 5th CLR_ST
    period = 32'd10; cont = 1'b1; tick_seen[0] = 0;
    push(0, 3'd2, 16'd9); push(0, 3'd3, 16'h0); push(0, 3'd1, 16'h0007);
    pulse_start(0);
    wait_ticks(0, 5, 200, "t2_five_ticks");
    chk("t2_count", 32'(tcnt[0]), 32'd5);
    push(0, 3'd1, 16'h0008); push(0, 3'd0, 16'h0000);
    stop[0] = 1'b1; cyc(); stop[0] = 1'b0;
    wait_idle(0, 20, "t2_stop_idle");
    chk("t2_ticks_after_stop", tick_seen[0], 5);

    // One-shot period 20
    period = 32'd20; cont = 1'b0; tick_seen[0] = 0;
    push(0, 3'd2, 16'd19); push(0, 3'd3, 16'h0); push(0, 3'd1, 16'h0005);
    pulse_start(0);
    wait_ticks(0, 1, 100, "t3_one_tick");
    wait_idle(0, 10, "t3_idle");
    repeat (40) cyc();
    chk("t3_single_tick", tick_seen[0], 1);
    chk("t3_count", 32'(tcnt[0]), 32'd1);
    chk("t3_no_more_writes", q0.size(), 0);

    // TICK_LIMIT=3 instance auto-stops after the third tick
    period = 32'd10; cont = 1'b1; tick_seen[1] = 0;
    push(1, 3'd2, 16'd9); push(1, 3'd3, 16'h0); push(1, 3'd1, 16'h0007);
    pulse_start(1);
    wait_idle(1, 300, "t4_auto_stop_idle");
    chk("t4_count", 32'(tcnt[1]), 32'd3);
    chk("t4_ticks", tick_seen[1], 3);
    chk("t4_queue_drained", q1.size(), 0);

    // Zero period rejected; stop while idle is silent
    period = 32'd0; cont = 1'b1;
    pulse_start(0);
    chk("t5_err_pulse", 32'(err[0]), 32'd1);
    chk("t5_err_not_busy", 32'(busy[0]), 32'd0);
    cyc();
    chk("t5_err_one_cycle", 32'(err[0]), 32'd0);
    chk("t5_count_kept", 32'(tcnt[0]), 32'd1);
    stop[0] = 1'b1; cyc(); stop[0] = 1'b0;
    repeat (4) cyc();
    chk("t5_idle_stop_busy", 32'(busy[0]), 32'd0);

    // Stop during WR_PH: full start completes, then the stop sequence
    period = 32'd1000;
    push(0, 3'd2, 16'd999); push(0, 3'd3, 16'h0); push(0, 3'd1, 16'h0007);
    push(0, 3'd1, 16'h0008); push(0, 3'd0, 16'h0000);
    pulse_start(0);
    cyc();
    stop[0] = 1'b1; cyc(); stop[0] = 1'b0;
    chk("t5_ctrl_still_written", 32'(addr[0]), 32'd1);
    chk("t5_count_cleared", 32'(tcnt[0]), 32'd0);
    wait_idle(0, 20, "t5_pend_stop_idle");
    repeat (3) cyc();
    chk("t5_stop_pend_cleared", 32'(busy[0]), 32'd0);

`ifdef TIMER_SNAPSHOT_EN
    // Snapshot with the model counter pinned at 0x00012345
    hold[0] = 1'b1; period = 32'h0010_0000; cont = 1'b1;
    push(0, 3'd2, 16'hFFFF); push(0, 3'd3, 16'h000F); push(0, 3'd1, 16'h0007);
    pulse_start(0);
    repeat (3) cyc();
    push(0, 3'd4, 16'h0000);
    sq0.push_back(32'h0001_2345);
    snap_seen = 0;
    snap_req[0] = 1'b1; cyc(); snap_req[0] = 1'b0;
    begin
      int k = 0;
      while (snap_seen == 0 && k < 20) begin cyc(); k++; end
    end
    chk("t6_snap_pulses", snap_seen, 1);
    cyc();
    chk("t6_single_pulse", snap_seen, 1);
    chk("t6_back_in_run", 32'(busy[0]), 32'd1);
    push(0, 3'd1, 16'h0008); push(0, 3'd0, 16'h0000);
    stop[0] = 1'b1; cyc(); stop[0] = 1'b0;
    wait_idle(0, 20, "t6_stop_idle");
    hold[0] = 1'b0;
`endif

    repeat (5) cyc();
    chk("end_q0_drained", q0.size(), 0);
    chk("end_q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
